// File: rtl/cpu_mc_pkg.sv
// Shared definitions for the multi-cycle CPU core.
// Holds the instruction field positions, opcode values, FSM state encoding,
// ALU operation encoding and small decode helpers used by the core and ALU.
package cpu_mc_pkg;

  // Instruction field bit positions (32-bit instruction word)
  localparam int OP_HI   = 31;
  localparam int OP_LO   = 26;
  localparam int RD_LO   = 21;
  localparam int RS1_LO  = 16;
  localparam int RS2_LO  = 0;
  localparam int IMM_HI  = 15;
  localparam int IMM_LO  = 0;
  localparam int IMM_W   = IMM_HI - IMM_LO + 1;

  // Opcodes
  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_SUB  = 6'h01;
  localparam logic [5:0] OP_AND  = 6'h02;
  localparam logic [5:0] OP_OR   = 6'h03;
  localparam logic [5:0] OP_XOR  = 6'h04;
  localparam logic [5:0] OP_SLT  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h10;
  localparam logic [5:0] OP_LW   = 6'h20;
  localparam logic [5:0] OP_SW   = 6'h21;
  localparam logic [5:0] OP_BEQ  = 6'h30;
  localparam logic [5:0] OP_JMP  = 6'h31;
  localparam logic [5:0] OP_HALT = 6'h3F;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    STOP,
    TRAP
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLT
  } alu_op_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT,
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_JMP, OP_HALT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // ADDI/LW/SW all need A+IMM, so everything non R-type maps to ADD.
  function automatic alu_op_t alu_op_of(input logic [5:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      OP_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_cpu_core_alu.sv
// mc_alu: combinational XLEN-wide ALU for the multi-cycle core.
// Ports:
//   op  in  3     ALU operation (alu_op_t encoding)
//   a   in  XLEN  first operand
//   b   in  XLEN  second operand
//   y   out XLEN  result (SLT yields 0/1, signed compare)
module mc_alu
  import cpu_mc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  always_comb begin
    y = a + b;
    case (alu_op_t'(op))
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SLT: y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      default: y = a + b;
    endcase
  end

endmodule

// File: rtl/multicycle_cpu_core.sv
// multicycle_cpu_core: multi-cycle CPU sharing one req/ack memory port for
// instruction fetch and load/store.
// Ports:
//   clk, rst         clock (rising edge), synchronous active-high reset
//   mem_req/mem_we   memory request (held until ack) / write select
//   mem_addr         byte address; mem_wdata store data
//   mem_rdata        read data, valid in the ack cycle (fetch uses [31:0])
//   mem_ack          transfer completes on an edge with req && ack
//   halted, illegal  sticky stop flags (HALT / undefined opcode)
// Optional macro PERF_COUNTERS_EN adds cycle_count and instret_count outputs.
module multicycle_cpu_core
  import cpu_mc_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NREG     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic            halted,
  output logic            illegal
`ifdef PERF_COUNTERS_EN
  ,
  output logic [XLEN-1:0] cycle_count,
  output logic [XLEN-1:0] instret_count
`endif
);

  localparam int RIDX_W = $clog2(NREG);

  state_t            state_reg;
  logic [XLEN-1:0]   pc_reg, npc_reg;
  logic [31:0]       ir_reg;
  logic [XLEN-1:0]   a_reg, b_reg, s_reg, imm_reg, y_reg;
  logic [XLEN-1:0]   regs [NREG];

  logic [5:0]        opcode;
  logic [RIDX_W-1:0] rd_idx, rs1_idx, rs2_idx;
  logic [XLEN-1:0]   imm_sext, alu_b, alu_y, pc_plus4, br_target;
  logic [2:0]        alu_op;
  logic              is_rtype, writes_rd, taken;

  // Register indices are the low bits of the 5-bit fields (modulo NREG).
  assign opcode   = ir_reg[OP_HI:OP_LO];
  assign rd_idx   = ir_reg[RD_LO +: RIDX_W];
  assign rs1_idx  = ir_reg[RS1_LO +: RIDX_W];
  assign rs2_idx  = ir_reg[RS2_LO +: RIDX_W];
  assign imm_sext = {{(XLEN-IMM_W){ir_reg[IMM_HI]}}, ir_reg[IMM_HI:IMM_LO]};

  assign is_rtype  = (opcode <= OP_SLT);
  assign writes_rd = is_rtype || (opcode == OP_ADDI) || (opcode == OP_LW);
  assign alu_b     = is_rtype ? b_reg : imm_reg;
  assign alu_op    = alu_op_of(opcode);
  assign taken     = (opcode == OP_JMP) || ((opcode == OP_BEQ) && (s_reg == a_reg));
  assign pc_plus4  = pc_reg + XLEN'(4);
  assign br_target = pc_plus4 + {imm_reg[XLEN-3:0], 2'b00};

  mc_alu #(.XLEN(XLEN)) u_alu (
    .op(alu_op),
    .a (a_reg),
    .b (alu_b),
    .y (alu_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= FETCH;
      pc_reg    <= RESET_PC;
      npc_reg   <= '0;
      ir_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      s_reg     <= '0;
      imm_reg   <= '0;
      y_reg     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      case (state_reg)
        FETCH: begin
          // After reset req is low, so the first fetch spends one cycle
          // raising it; later fetches are issued directly from WB.
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc_reg;
          end else if (mem_ack) begin
            ir_reg    <= mem_rdata[31:0];
            mem_req   <= 1'b0;
            state_reg <= DECODE;
          end
        end
        DECODE: begin
          a_reg   <= regs[rs1_idx];
          b_reg   <= regs[rs2_idx];
          s_reg   <= regs[rd_idx];
          imm_reg <= imm_sext;
          if (!is_legal_op(opcode)) begin
            illegal   <= 1'b1;
            state_reg <= TRAP;
          end else begin
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          y_reg   <= alu_y;
          npc_reg <= taken ? br_target : pc_plus4;
          if ((opcode == OP_LW) || (opcode == OP_SW)) begin
            mem_req   <= 1'b1;
            mem_we    <= (opcode == OP_SW);
            mem_addr  <= alu_y;
            mem_wdata <= s_reg;
            state_reg <= MEM;
          end else if (opcode == OP_HALT) begin
            halted    <= 1'b1;
            state_reg <= STOP;
          end else begin
            state_reg <= WB;
          end
        end
        MEM: begin
          if (mem_ack) begin
            if (!mem_we) y_reg <= mem_rdata;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            state_reg <= WB;
          end
        end
        WB: begin
          if (writes_rd && (rd_idx != '0)) regs[rd_idx] <= y_reg;
          pc_reg    <= npc_reg;
          mem_req   <= 1'b1;
          mem_we    <= 1'b0;
          mem_addr  <= npc_reg;
          state_reg <= FETCH;
        end
        STOP, TRAP: state_reg <= state_reg;
        default: begin
          illegal   <= 1'b1;
          state_reg <= TRAP;
        end
      endcase
    end
  end

`ifdef PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      if ((state_reg != STOP) && (state_reg != TRAP)) cycle_count <= cycle_count + 1'b1;
      if (state_reg == WB) instret_count <= instret_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_cpu_core.sv
module tb_multicycle_cpu_core;

  localparam logic [5:0] T_ADD = 6'h00, T_SUB = 6'h01, T_AND = 6'h02, T_OR = 6'h03;
  localparam logic [5:0] T_XOR = 6'h04, T_SLT = 6'h05, T_ADDI = 6'h10, T_LW = 6'h20;
  localparam logic [5:0] T_SW = 6'h21, T_BEQ = 6'h30, T_JMP = 6'h31;
  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  logic        clk, rst;
  logic        mem_req, mem_we, mem_ack, halted, illegal;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef PERF_COUNTERS_EN
  logic [31:0] cycle_count, instret_count;
`endif

  logic [31:0] mem  [0:63];
  logic [31:0] prog [0:31];
  logic [31:0] log_addr [0:1023];
  logic [31:0] log_data [0:1023];
  logic        log_we   [0:1023];
  int          log_n = 0;
  int          wait_cnt = 0;
  int          ack_delay = 0;
  bit          ack_en = 1;
  logic        ld_en;
  logic [5:0]  ld_addr;
  logic [31:0] ld_data;
  int          total = 0;
  int          bad = 0;

  multicycle_cpu_core #(.XLEN(32), .NREG(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .halted(halted), .illegal(illegal)
`ifdef PERF_COUNTERS_EN
    , .cycle_count(cycle_count), .instret_count(instret_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: 64 words at 0x00..0xFC; anything else reads as HALT.
  assign mem_rdata = (mem_addr[31:8] == 24'd0) ? mem[mem_addr[7:2]] : HALT_W;

  always @(negedge clk)
    mem_ack = mem_req && !rst && ack_en && (wait_cnt >= ack_delay);

  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (!rst && mem_req && mem_ack) begin
      if (mem_we && (mem_addr[31:8] == 24'd0)) mem[mem_addr[7:2]] <= mem_wdata;
      log_addr[log_n % 1024] <= mem_addr;
      log_we[log_n % 1024]   <= mem_we;
      log_data[log_n % 1024] <= mem_we ? mem_wdata : mem_rdata;
      log_n <= log_n + 1;
      $display("xfer %0s addr=%08h data=%08h", mem_we ? "wr" : "rd", mem_addr,
               mem_we ? mem_wdata : mem_rdata);
    end
    if (rst || !mem_req || mem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  function automatic logic [31:0] r_ins(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, 11'd0, rs2};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [15:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  // Holds rst high while the program is written; returns at a negedge with rst=1.
  task automatic load_prog(input int n);
    rst = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = 6'(i);
      ld_data = (i < n) ? prog[i] : HALT_W;
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic run_to_stop(input int budget, output bit done);
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk);
      if (halted || illegal) done = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0b want=0", mem_req); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%0b want=0", mem_we); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%08h want=0", mem_addr); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%08h want=0", mem_wdata); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%0b want=0", halted); end
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%0b want=0", illegal); end
  endtask

  // ADDI, ADDI, ADD, HALT at ack=1: 1 cycle to raise the first req, then
  // 4 cycles per instruction, HALT stopping at its EXEC: halted after 16 edges.
  task automatic test_basic;
    int base;
    prog[0] = i_ins(T_ADDI, 1, 0, 16'd5);
    prog[1] = i_ins(T_ADDI, 2, 0, 16'hFFFD);
    prog[2] = r_ins(T_ADD, 3, 1, 2);
    prog[3] = HALT_W;
    load_prog(4);
    base = log_n;
    rst = 1'b0;
    repeat (15) @(negedge clk);
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL basic_early_halt got=%0b want=0", halted); end
    @(negedge clk);
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL basic_halt_time got=%0b want=1", halted); end
    repeat (5) @(negedge clk);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL basic_req_after_halt got=%0b want=0", mem_req); end
    total++; if (log_n - base !== 4) begin bad++; $display("FAIL basic_xfer_count got=%0d want=4", log_n - base); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (log_addr[(base + i) % 1024] !== 32'(4 * i) || log_we[(base + i) % 1024] !== 1'b0) begin
        bad++;
        $display("FAIL basic_fetch%0d got=%08h we=%0b want=%08h we=0", i,
                 log_addr[(base + i) % 1024], log_we[(base + i) % 1024], 4 * i);
      end
    end
  endtask

  task automatic test_alu;
    int base, nw;
    bit done;
    logic [5:0]  ops [0:6];
    logic [4:0]  sa  [0:6];
    logic [4:0]  sb  [0:6];
    logic [31:0] exp_w [0:6];
    ops = '{T_ADD, T_SUB, T_AND, T_OR, T_XOR, T_SLT, T_SLT};
    sa  = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd2};
    sb  = '{5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd1};
    // R1=5, R2=-3
    exp_w = '{32'd2, 32'd8, 32'd5, 32'hFFFF_FFFD, 32'hFFFF_FFF8, 32'd0, 32'd1};
    prog[0] = i_ins(T_ADDI, 1, 0, 16'd5);
    prog[1] = i_ins(T_ADDI, 2, 0, 16'hFFFD);
    for (int j = 0; j < 7; j++) begin
      prog[2 + 2 * j] = r_ins(ops[j], 3, sa[j], sb[j]);
      prog[3 + 2 * j] = i_ins(T_SW, 3, 0, 16'(32'h80 + 4 * j));
    end
    prog[16] = HALT_W;
    load_prog(17);
    base = log_n;
    rst = 1'b0;
    run_to_stop(400, done);
    total++; if (!done || halted !== 1'b1) begin bad++; $display("FAIL alu_halt got=%0b want=1", halted); end
    nw = 0;
    for (int i = base; i < log_n; i++) begin
      if (log_we[i % 1024]) begin
        if (nw < 7) begin
          total++;
          if (log_addr[i % 1024] !== 32'(32'h80 + 4 * nw) || log_data[i % 1024] !== exp_w[nw]) begin
            bad++;
            $display("FAIL alu_result%0d got addr=%08h data=%08h want addr=%08h data=%08h", nw,
                     log_addr[i % 1024], log_data[i % 1024], 32'h80 + 4 * nw, exp_w[nw]);
          end
        end
        nw++;
      end
    end
    total++; if (nw !== 7) begin bad++; $display("FAIL alu_store_count got=%0d want=7", nw); end
  endtask

  // SW/LW with 3 wait cycles per request; address/data/we must hold while waiting.
  task automatic test_mem;
    int base, nw, unstable, wait_total;
    bit in_req, done;
    logic [31:0] s_addr, s_wdata;
    logic s_we;
    prog[0] = i_ins(T_ADDI, 1, 0, 16'd5);
    prog[1] = i_ins(T_SW, 1, 0, 16'h40);
    prog[2] = i_ins(T_LW, 4, 0, 16'h40);
    prog[3] = i_ins(T_SW, 4, 0, 16'h44);
    prog[4] = HALT_W;
    ack_delay = 3;
    load_prog(5);
    base = log_n;
    unstable = 0; wait_total = 0; in_req = 1'b0; done = 1'b0;
    s_addr = '0; s_wdata = '0; s_we = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      #1;
      if (mem_req) begin
        if (in_req) begin
          if (mem_addr !== s_addr || mem_wdata !== s_wdata || mem_we !== s_we) unstable++;
        end else begin
          s_addr = mem_addr; s_wdata = mem_wdata; s_we = mem_we;
        end
        in_req = !mem_ack;
        if (!mem_ack) wait_total++;
      end else begin
        in_req = 1'b0;
      end
      if (halted || illegal) done = 1'b1;
    end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL mem_halt got=%0b want=1", halted); end
    total++; if (unstable !== 0) begin bad++; $display("FAIL mem_stable got=%0d changes want=0", unstable); end
    total++; if (wait_total !== 24) begin bad++; $display("FAIL mem_wait_cycles got=%0d want=24", wait_total); end
    nw = 0;
    for (int i = base; i < log_n; i++) begin
      if (log_we[i % 1024]) begin
        if (nw < 2) begin
          total++;
          if (log_addr[i % 1024] !== 32'(32'h40 + 4 * nw) || log_data[i % 1024] !== 32'd5) begin
            bad++;
            $display("FAIL mem_store%0d got addr=%08h data=%08h want addr=%08h data=00000005", nw,
                     log_addr[i % 1024], log_data[i % 1024], 32'h40 + 4 * nw);
          end
        end
        nw++;
      end
    end
    total++; if (nw !== 2) begin bad++; $display("FAIL mem_store_count got=%0d want=2", nw); end
    ack_delay = 0;
  endtask

  // JMP +1 -> 0x08; BEQ R1,R0,-2 taken (R1=0) -> 0x04; ADDI R1=1; BEQ not taken -> 0x0C HALT.
  task automatic test_branch;
    int base;
    bit done;
    logic [31:0] exp_f [0:4];
    exp_f = '{32'h00, 32'h08, 32'h04, 32'h08, 32'h0C};
    prog[0] = i_ins(T_JMP, 0, 0, 16'd1);
    prog[1] = i_ins(T_ADDI, 1, 0, 16'd1);
    prog[2] = i_ins(T_BEQ, 1, 0, 16'hFFFE);
    prog[3] = HALT_W;
    load_prog(4);
    base = log_n;
    rst = 1'b0;
    run_to_stop(200, done);
    total++; if (!done || halted !== 1'b1) begin bad++; $display("FAIL branch_halt got=%0b want=1", halted); end
    total++; if (log_n - base !== 5) begin bad++; $display("FAIL branch_fetch_count got=%0d want=5", log_n - base); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (log_addr[(base + i) % 1024] !== exp_f[i]) begin
        bad++;
        $display("FAIL branch_fetch%0d got=%08h want=%08h", i, log_addr[(base + i) % 1024], exp_f[i]);
      end
    end
  endtask

  // JMP at 0: +0x7FFF -> 0x4+0x1FFFC=0x20000; -2 -> 0x4-0x8 wraps to 0xFFFFFFFC.
  task automatic test_jump;
    int base;
    bit done;
    logic [15:0] imms [0:1];
    logic [31:0] tgts [0:1];
    imms = '{16'h7FFF, 16'hFFFE};
    tgts = '{32'h0002_0000, 32'hFFFF_FFFC};
    for (int t = 0; t < 2; t++) begin
      prog[0] = i_ins(T_JMP, 0, 0, imms[t]);
      load_prog(1);
      base = log_n;
      rst = 1'b0;
      run_to_stop(100, done);
      total++; if (!done || halted !== 1'b1) begin bad++; $display("FAIL jump%0d_halt got=%0b want=1", t, halted); end
      total++;
      if (log_addr[(base + 1) % 1024] !== tgts[t]) begin
        bad++;
        $display("FAIL jump%0d_target got=%08h want=%08h", t, log_addr[(base + 1) % 1024], tgts[t]);
      end
    end
  endtask

  task automatic test_r0;
    int nw;
    bit done;
    logic [31:0] exp_d [0:1];
    int base;
    exp_d = '{32'd0, 32'd1};
    prog[0] = i_ins(T_ADDI, 1, 0, 16'd7);
    prog[1] = r_ins(T_ADD, 0, 1, 1);
    prog[2] = i_ins(T_SW, 0, 0, 16'h80);
    prog[3] = i_ins(T_ADDI, 5, 0, 16'd1);
    prog[4] = i_ins(T_SW, 5, 0, 16'h84);
    prog[5] = HALT_W;
    load_prog(6);
    base = log_n;
    rst = 1'b0;
    run_to_stop(200, done);
    total++; if (!done || halted !== 1'b1) begin bad++; $display("FAIL r0_halt got=%0b want=1", halted); end
    nw = 0;
    for (int i = base; i < log_n; i++) begin
      if (log_we[i % 1024]) begin
        if (nw < 2) begin
          total++;
          if (log_data[i % 1024] !== exp_d[nw]) begin
            bad++;
            $display("FAIL r0_store%0d got=%08h want=%08h", nw, log_data[i % 1024], exp_d[nw]);
          end
        end
        nw++;
      end
    end
    total++; if (nw !== 2) begin bad++; $display("FAIL r0_store_count got=%0d want=2", nw); end
  endtask

  task automatic test_illegal;
    int base, req_seen;
    bit done;
    prog[0] = i_ins(T_ADDI, 1, 0, 16'd1);
    prog[1] = 32'hF800_0000;  // opcode 0x3E
    prog[2] = HALT_W;
    load_prog(3);
    base = log_n;
    rst = 1'b0;
    run_to_stop(100, done);
    total++; if (!done || illegal !== 1'b1) begin bad++; $display("FAIL illegal_flag got=%0b want=1", illegal); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL illegal_halted got=%0b want=0", halted); end
    req_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_req !== 1'b0) req_seen++;
    end
    total++; if (req_seen !== 0) begin bad++; $display("FAIL illegal_req got=%0d cycles want=0", req_seen); end
    total++; if (log_n - base !== 2) begin bad++; $display("FAIL illegal_xfers got=%0d want=2", log_n - base); end
  endtask

  task automatic test_reset_midfetch;
    int base;
    bit done;
    prog[0] = i_ins(T_ADDI, 1, 0, 16'd5);
    prog[1] = HALT_W;
    load_prog(2);
    ack_en = 1'b0;
    base = log_n;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      bad++;
      $display("FAIL rstmid_pending got req=%0b addr=%08h want req=1 addr=0", mem_req, mem_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rstmid_req_drop got=%0b want=0", mem_req); end
    total++; if (log_n !== base) begin bad++; $display("FAIL rstmid_abandon got=%0d xfers want=0", log_n - base); end
    ack_en = 1'b1;
    rst = 1'b0;
    run_to_stop(100, done);
    total++; if (!done || halted !== 1'b1) begin bad++; $display("FAIL rstmid_halt got=%0b want=1", halted); end
    total++;
    if (log_addr[base % 1024] !== 32'h0) begin
      bad++;
      $display("FAIL rstmid_refetch got=%08h want=00000000", log_addr[base % 1024]);
    end
  endtask

`ifdef PERF_COUNTERS_EN
  task automatic test_perf;
    bit done;
    prog[0] = i_ins(T_ADDI, 1, 0, 16'd5);
    prog[1] = i_ins(T_ADDI, 2, 0, 16'hFFFD);
    prog[2] = r_ins(T_ADD, 3, 1, 2);
    prog[3] = HALT_W;
    load_prog(4);
    total++; if (cycle_count !== 32'd0) begin bad++; $display("FAIL perf_reset_cycle got=%0d want=0", cycle_count); end
    rst = 1'b0;
    run_to_stop(100, done);
    total++; if (instret_count !== 32'd3) begin bad++; $display("FAIL perf_instret got=%0d want=3", instret_count); end
    total++; if (cycle_count !== 32'd16) begin bad++; $display("FAIL perf_cycle got=%0d want=16", cycle_count); end
    repeat (8) @(negedge clk);
    total++; if (cycle_count !== 32'd16) begin bad++; $display("FAIL perf_cycle_frozen got=%0d want=16", cycle_count); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    ld_en = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    mem_ack = 1'b0;
    test_reset;
    test_basic;
    test_alu;
    test_mem;
    test_branch;
    test_jump;
    test_r0;
    test_illegal;
    test_reset_midfetch;
`ifdef PERF_COUNTERS_EN
    test_perf;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_cpu_core.md
Name: multicycle_cpu_core

Overview:
Parametrised multi-cycle successor to the single-cycle CPU top. It keeps the same 32-bit instruction format: opcode[31:26], rd[25:21], rs1[20:16], rs2[4:0], imm[15:0]. Instruction fetch and load/store are sequenced through one shared memory port with a req/ack handshake, which removes the single-cycle memory assumption. It sits between the system memory/bus and the rest of the platform; the only status outputs are halt and illegal-instruction flags.

Parameters:
XLEN, 32, datapath/register/address width; must be >= 32.
NREG, 32, architectural register count; power of 2, 2..32; register index = field modulo NREG.
RESET_PC, 0, byte address loaded into PC on reset; must be 4-aligned.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = write (SW), 0 = read (fetch/LW)
mem_addr  out  XLEN  byte address
mem_wdata  out  XLEN  store data
mem_rdata  in  XLEN  read data, valid in ack cycle; fetch uses [31:0]
mem_ack  in  1  transfer completes on an edge where req && ack
halted  out  1  core stopped on HALT; sticky until rst
illegal  out  1  core stopped on undefined opcode; sticky until rst

Behaviour:
- Reset: PC=RESET_PC, state=FETCH, all registers 0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0, illegal=0.
- R0 always reads 0; writes to R0 are discarded.
- FSM states and transitions:
  - FETCH: req=1, we=0, addr=PC. On ack: IR<=rdata[31:0] → DECODE.
  - DECODE: A<=R[rs1], B<=R[rs2], S<=R[rd], IMM<=sext(imm) → EXEC. Illegal opcode → TRAP.
  - EXEC: ALU/address/branch compute. LW/SW → MEM; HALT → STOP; others → WB.
  - MEM: req=1, addr=A+IMM, we=(SW), wdata=S. On ack → WB.
  - WB: register write (R-type, ADDI, LW); PC update → FETCH.
  - STOP and TRAP are absorbing until rst.
- Opcodes:
  - 0x00 ADD, 0x01 SUB, 0x02 AND, 0x03 OR, 0x04 XOR, 0x05 SLT (signed): R[rd]=A op B.
  - 0x10 ADDI: R[rd]=A+IMM.
  - 0x20 LW: R[rd]=rdata. 0x21 SW: mem[A+IMM]=R[rd].
  - 0x30 BEQ: if R[rd]==A, PC=PC+4+(IMM<<2).
  - 0x31 JMP: PC=PC+4+(IMM<<2).
  - 0x3F HALT.
  - All other opcodes are illegal.
- Non-taken and non-branch instructions: PC=PC+4.
- All arithmetic is modulo 2^XLEN; no flags are kept. Address is A+IMM unaligned-passed (the memory ignores [1:0]).
- Latency: ALU/branch = 4 cycles + fetch wait; LW/SW = 5 cycles + both waits. With ack in the same cycle as req, fetch costs 1 cycle.
- mem_addr, mem_we and mem_wdata are stable while req=1 and no ack has occurred. req drops the cycle after ack.
- rst mid-transfer: req drops next cycle and the outstanding access is abandoned; memory must tolerate this.
- halted and illegal are mutually exclusive. In STOP/TRAP: mem_req=0 and PC frozen.

Optional Feature:
PERF_COUNTERS_EN:
- Defined: adds outputs cycle_count[XLEN-1:0] and instret_count[XLEN-1:0].
  - cycle_count increments every non-reset cycle until STOP/TRAP.
  - instret_count increments on each WB→FETCH transition.
  - Both are 0 on rst and wrap at 2^XLEN.
- Undefined: the ports and logic are absent.

Decomposition:
- Package cpu_mc_pkg holds:
  - opcode localparams
  - state enum (FETCH, DECODE, EXEC, MEM, WB, STOP, TRAP)
  - ALU op encoding
  - field bit-position constants
- One sub-module, mc_alu: combinational XLEN ALU for ADD/SUB/AND/OR/XOR/SLT. Register file and FSM stay in the core.

Test Plan:
- Reset then ADDI R1,R0,5; ADDI R2,R0,-3; ADD R3,R1,R2; HALT, with ack=1 every cycle → R3=2, halted=1 after 4×4-cycle instructions, mem_req=0 after.
- SW R1→[R0+0x40], then LW R4←[R0+0x40], with ack delayed 3 cycles per request → write seen with addr=0x40, wdata=5; R4=5; addr/wdata stable during wait.
- BEQ taken (IMM=-2) and not taken → PC=PC+4-8 and PC+4 respectively; JMP IMM=0x7FFF → correct target; wrap at 2^XLEN with XLEN=32.
- Opcode 0x3E → illegal=1, halted=0, no further mem_req; ADD into R0 → R0 stays 0.
- Assert rst while FETCH req is pending and ack never given → req=0 next cycle, PC=RESET_PC, fetch restarts.
- With PERF_COUNTERS_EN defined: 3 instructions + HALT at ack=1 → instret_count=3, cycle_count frozen at STOP entry value.
